// File: rtl/apb_req_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module   : apb_req_arbiter_if
// Brief    : Requester, response and APB-master-side bundle of the arbiter.
// Revision : 1.0
// ============================================================================
interface apb_req_arbiter_if #(
    parameter int NUM_REQ    = 4,
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
);
    logic [NUM_REQ-1:0]            req_valid;
    logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr;
    logic [NUM_REQ-1:0]            req_write;
    logic [NUM_REQ*DATA_WIDTH-1:0] req_wdata;
    logic [NUM_REQ-1:0]            req_ready;
    logic [NUM_REQ-1:0]            rsp_valid;
    logic [DATA_WIDTH-1:0]         rsp_rdata;
    logic                          rsp_err;
    logic                          mst_start;
    logic [ADDR_WIDTH-1:0]         mst_addr;
    logic                          mst_write;
    logic [DATA_WIDTH-1:0]         mst_wdata;
    logic                          mst_done;
    logic [DATA_WIDTH-1:0]         mst_rdata;
    logic                          mst_slverr;
    logic                          busy;
    logic [2:0]                    grant_id;
    logic                          timeout_flag;

    // The arbiter itself connects through the slave view.
    modport slave (
        input  req_valid, req_addr, req_write, req_wdata,
        input  mst_done, mst_rdata, mst_slverr,
        output req_ready, rsp_valid, rsp_rdata, rsp_err,
        output mst_start, mst_addr, mst_write, mst_wdata,
        output busy, grant_id, timeout_flag
    );

    modport master (
        output req_valid, req_addr, req_write, req_wdata,
        output mst_done, mst_rdata, mst_slverr,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err,
        input  mst_start, mst_addr, mst_write, mst_wdata,
        input  busy, grant_id, timeout_flag
    );
endinterface
`default_nettype wire

// File: rtl/apb_req_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : apb_req_arbiter
// Brief    : Round-robin arbiter funnelling N requesters onto one APB master.
// Revision : 1.0
// ============================================================================
module apb_req_arbiter #(
    parameter int NUM_REQ    = 4,
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int TIMEOUT    = 256
) (
    input  wire logic        PCLK,
    input  wire logic        PRESET,
    apb_req_arbiter_if.slave bus
);
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_RESP  = 2'd3
    } state_t;

    localparam logic [15:0] TO_LAST  = 16'(TIMEOUT - 1);
    localparam logic [2:0]  LAST_RST = 3'(NUM_REQ - 1);

    state_t                  state_q;
    logic [2:0]              last_grant_q;
    logic [2:0]              grant_q;
    logic [15:0]             cnt_q;
    logic                    tflag_q;
    logic                    busy_q;
    logic                    mst_start_q;
    logic [ADDR_WIDTH-1:0]   mst_addr_q;
    logic                    mst_write_q;
    logic [DATA_WIDTH-1:0]   mst_wdata_q;
    logic [NUM_REQ-1:0]      req_ready_q;
    logic [NUM_REQ-1:0]      rsp_valid_q;
    logic [DATA_WIDTH-1:0]   rsp_rdata_q;
    logic                    rsp_err_q;

    logic [2:0]              grant_d;
    logic [ADDR_WIDTH-1:0]   addr_d;
    logic                    write_d;
    logic [DATA_WIDTH-1:0]   wdata_d;
    logic [NUM_REQ-1:0]      ready_d;
    logic [NUM_REQ-1:0]      rsp_vec_d;
    logic [2:0]              hi_idx;
    logic [2:0]              lo_idx;
    logic                    hi_found;

    // Round robin: lowest valid index above last_grant, else lowest valid at or below it.
    always_comb begin
        hi_idx   = '0;
        lo_idx   = '0;
        hi_found = 1'b0;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            if (bus.req_valid[i] && (3'(i) > last_grant_q)) begin
                hi_idx   = 3'(i);
                hi_found = 1'b1;
            end
            if (bus.req_valid[i] && (3'(i) <= last_grant_q)) begin
                lo_idx = 3'(i);
            end
        end
        grant_d = hi_found ? hi_idx : lo_idx;
    end

    always_comb begin
        addr_d    = '0;
        write_d   = 1'b0;
        wdata_d   = '0;
        ready_d   = '0;
        rsp_vec_d = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (grant_d == 3'(i)) begin
                addr_d     = bus.req_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
                write_d    = bus.req_write[i];
                wdata_d    = bus.req_wdata[i*DATA_WIDTH +: DATA_WIDTH];
                ready_d[i] = 1'b1;
            end
            rsp_vec_d[i] = (grant_q == 3'(i));
        end
    end

    always_ff @(posedge PCLK or posedge PRESET) begin
        if (PRESET) begin
            state_q      <= ST_IDLE;
            last_grant_q <= LAST_RST;
            grant_q      <= '0;
            cnt_q        <= '0;
            tflag_q      <= 1'b0;
            busy_q       <= 1'b0;
            mst_start_q  <= 1'b0;
            mst_addr_q   <= '0;
            mst_write_q  <= 1'b0;
            mst_wdata_q  <= '0;
            req_ready_q  <= '0;
            rsp_valid_q  <= '0;
            rsp_rdata_q  <= '0;
            rsp_err_q    <= 1'b0;
        end else begin
            req_ready_q <= '0;
            rsp_valid_q <= '0;
            mst_start_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (|bus.req_valid) begin
                        grant_q     <= grant_d;
                        mst_addr_q  <= addr_d;
                        mst_write_q <= write_d;
                        mst_wdata_q <= wdata_d;
                        req_ready_q <= ready_d;
                        busy_q      <= 1'b1;
                        state_q     <= ST_ISSUE;
                    end
                end
                ST_ISSUE: begin
                    mst_start_q <= 1'b1;
                    cnt_q       <= '0;
                    state_q     <= ST_WAIT;
                end
                ST_WAIT: begin
                    cnt_q <= cnt_q + 16'd1;
                    // A completion in the final counted cycle beats the timeout.
                    if (bus.mst_done) begin
                        rsp_rdata_q <= bus.mst_rdata;
                        rsp_err_q   <= bus.mst_slverr;
                        rsp_valid_q <= rsp_vec_d;
                        state_q     <= ST_RESP;
                    end else if (cnt_q == TO_LAST) begin
                        rsp_rdata_q <= '0;
                        rsp_err_q   <= 1'b1;
                        tflag_q     <= 1'b1;
                        rsp_valid_q <= rsp_vec_d;
                        state_q     <= ST_RESP;
                    end
                end
                ST_RESP: begin
                    last_grant_q <= grant_q;
                    busy_q       <= 1'b0;
                    state_q      <= ST_IDLE;
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign bus.req_ready    = req_ready_q;
    assign bus.rsp_valid    = rsp_valid_q;
    assign bus.rsp_rdata    = rsp_rdata_q;
    assign bus.rsp_err      = rsp_err_q;
    assign bus.mst_start    = mst_start_q;
    assign bus.mst_addr     = mst_addr_q;
    assign bus.mst_write    = mst_write_q;
    assign bus.mst_wdata    = mst_wdata_q;
    assign bus.busy         = busy_q;
    assign bus.grant_id     = grant_q;
    assign bus.timeout_flag = tflag_q;
endmodule
`default_nettype wire
